// File: rtl/pcjr_shared_ram_arbiter.sv
// Shares the 128 KiB system/video RAM between the 8088 bus and the video fetch engine.
// Video fetches win arbitration, but only VIDEO_RUN_MAX in a row while a CPU cycle waits.
module pcjr_shared_ram_arbiter #(
  parameter int          VIDEO_RUN_MAX = 4,
  parameter logic [19:0] SHARED_TOP    = 20'h20000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] ADDRESS,
  input  logic [7:0]  DATA_IN,
  output logic [7:0]  DATA_OUT,
  output logic        data_out_valid,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic        IO_OR_M,
  input  logic        ALE,
  output logic        RDY,
  input  logic        video_req,
  input  logic [16:0] video_address,
  output logic        video_busy,
  output logic        video_ack,
  output logic [7:0]  video_data,
  output logic [16:0] ram_address,
  output logic [7:0]  ram_data_out,
  output logic        ram_read,
  output logic        ram_write,
  input  logic [7:0]  ram_data_in,
  input  logic        ram_ack
);
  localparam int               RUN_W   = $clog2(VIDEO_RUN_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(VIDEO_RUN_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_VIDEO, S_CPU_STROBE, S_CPU_ACCESS, S_CPU_DONE
  } state_t;

  state_t           r_state;
  logic [16:0]      r_cpu_addr;
  logic [16:0]      r_vid_addr;
  logic             r_cpu_pending;
  logic             r_cpu_read;
  logic [RUN_W-1:0] r_run;

  logic        w_cpu_shared;
  logic        w_vid_take;
  logic        w_vid_pend;
  logic [16:0] w_vid_addr;

  // The latched CPU cycle is frozen from ALE until CPU_DONE exits.
  assign w_cpu_shared = ALE & ~IO_OR_M & (ADDRESS < SHARED_TOP) & ~r_cpu_pending;
  assign w_vid_take   = video_req & ~video_busy;
  // A fresh request is granted straight from IDLE, giving a 1-clock path to ram_read.
  assign w_vid_pend   = video_busy | w_vid_take;
  assign w_vid_addr   = video_busy ? r_vid_addr : video_address;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cpu_addr     <= '0;
      r_vid_addr     <= '0;
      r_cpu_pending  <= 1'b0;
      r_cpu_read     <= 1'b0;
      r_run          <= '0;
      RDY            <= 1'b1;
      DATA_OUT       <= '0;
      data_out_valid <= 1'b0;
      video_busy     <= 1'b0;
      video_ack      <= 1'b0;
      video_data     <= '0;
      ram_address    <= '0;
      ram_data_out   <= '0;
      ram_read       <= 1'b0;
      ram_write      <= 1'b0;
    end else begin
      video_ack <= 1'b0;
      if (w_vid_take) begin
        r_vid_addr <= video_address;
        video_busy <= 1'b1;
      end
      if (w_cpu_shared) begin
        r_cpu_addr    <= ADDRESS[16:0];
        r_cpu_pending <= 1'b1;
        RDY           <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_vid_pend && (!r_cpu_pending || r_run < RUN_MAX)) begin
            ram_read    <= 1'b1;
            ram_address <= w_vid_addr;
            r_state     <= S_VIDEO;
          end else if (r_cpu_pending) begin
            r_state <= S_CPU_STROBE;
          end
        end
        S_VIDEO: begin
          if (ram_ack) begin
            ram_read   <= 1'b0;
            video_data <= ram_data_in;
            video_ack  <= 1'b1;
            video_busy <= 1'b0;
            if (r_cpu_pending && r_run < RUN_MAX) r_run <= r_run + RUN_W'(1);
            r_state <= S_IDLE;
          end
        end
        S_CPU_STROBE: begin
          if (!RD_N || !WR_N) begin
            ram_address <= r_cpu_addr;
            if (!WR_N) begin
              ram_write    <= 1'b1;
              ram_data_out <= DATA_IN;
              r_cpu_read   <= 1'b0;
            end else begin
              ram_read   <= 1'b1;
              r_cpu_read <= 1'b1;
            end
            r_state <= S_CPU_ACCESS;
          end
        end
        S_CPU_ACCESS: begin
          if (ram_ack) begin
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            if (r_cpu_read) DATA_OUT <= ram_data_in;
            RDY     <= 1'b1;
            r_run   <= '0;
            r_state <= S_CPU_DONE;
          end
        end
        S_CPU_DONE: begin
          if (RD_N && WR_N) begin
            data_out_valid <= 1'b0;
            r_cpu_pending  <= 1'b0;
            r_state        <= S_IDLE;
          end else begin
            data_out_valid <= r_cpu_read & ~RD_N;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pcjr_shared_ram_arbiter.sv
// Scoreboard bench: a RAM responder, a random video requester and an 8088 bus task feed
// expected bytes into queues that a negedge monitor checks against the DUT outputs.
module tb_pcjr_shared_ram_arbiter;
  logic        clock = 1'b0, reset = 1'b1;
  logic [19:0] ADDRESS = '0;
  logic [7:0]  DATA_IN = '0;
  logic        RD_N = 1'b1, WR_N = 1'b1, IO_OR_M = 1'b0, ALE = 1'b0;
  logic        video_req = 1'b0;
  logic [16:0] video_address = '0;
  logic [7:0]  ram_data_in = '0;
  logic        ram_ack = 1'b0;
  logic [7:0]  DATA_OUT, video_data, ram_data_out;
  logic        data_out_valid, RDY, video_busy, video_ack, ram_read, ram_write;
  logic [16:0] ram_address;

  pcjr_shared_ram_arbiter #(.VIDEO_RUN_MAX(4), .SHARED_TOP(20'h20000)) dut (
    .clock(clock), .reset(reset), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN),
    .DATA_OUT(DATA_OUT), .data_out_valid(data_out_valid), .RD_N(RD_N), .WR_N(WR_N),
    .IO_OR_M(IO_OR_M), .ALE(ALE), .RDY(RDY), .video_req(video_req),
    .video_address(video_address), .video_busy(video_busy), .video_ack(video_ack),
    .video_data(video_data), .ram_address(ram_address), .ram_data_out(ram_data_out),
    .ram_read(ram_read), .ram_write(ram_write), .ram_data_in(ram_data_in), .ram_ack(ram_ack)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic w; logic [16:0] a; } cmd_t;

  logic [7:0]  ram   [0:131071];
  logic [7:0]  model [0:131071];
  logic [7:0]  vid_q[$];
  logic [7:0]  rd_q[$];
  logic [24:0] wr_q[$];
  cmd_t        cmd_log[$];
  int n_chk = 0, n_pass = 0;
  int vid_acks = 0, acks_in_wait = 0, viol = 0;
  int vid_pct = 0, fixed_dly = 0;
  bit vid_en = 0, mbusy = 0, ram_hold = 0, stray = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Video requester: busy is modelled as set on acceptance and cleared by video_ack.
  initial forever begin
    tick();
    if (video_ack) mbusy = 0;
    if (vid_en && $urandom_range(99) < vid_pct) begin
      video_req = 1'b1;
      video_address = 17'($urandom_range(32'hFFFF));
      if (!mbusy) begin
        vid_q.push_back(model[video_address]);
        mbusy = 1;
      end
    end else video_req = 1'b0;
  end

  // RAM responder with random (or fixed) ack latency.
  initial begin
    cmd_t c;
    logic [24:0] e;
    forever begin
      tick();
      if (stray) begin
        ram_ack = 1'b1; tick(); ram_ack = 1'b0; stray = 0;
      end else if ((ram_read || ram_write) && !ram_hold) begin
        c.w = ram_write; c.a = ram_address;
        cmd_log.push_back(c);
        if (ram_write) begin
          if (wr_q.size() == 0) chk("ram_write_unexpected", ram_write, 0);
          else begin
            e = wr_q.pop_front();
            chk("ram_write_addr", ram_address, e[24:8]);
            chk("ram_write_data", ram_data_out, e[7:0]);
          end
        end
        repeat (fixed_dly != 0 ? fixed_dly : int'($urandom_range(3))) tick();
        ram_ack = 1'b1;
        if (ram_write) ram[ram_address] = ram_data_out;
        else ram_data_in = ram[ram_address];
        tick();
        ram_ack = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboards whenever the DUT presents data.
  initial begin
    logic prev_dov, prev_cmd;
    logic [16:0] prev_addr;
    prev_dov = 0; prev_cmd = 0; prev_addr = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (video_ack) begin
          vid_acks++;
          if (!RDY) acks_in_wait++;
          if (vid_q.size() == 0) chk("video_ack_unexpected", video_ack, 0);
          else chk("video_data", video_data, vid_q.pop_front());
        end
        if (data_out_valid && !prev_dov) begin
          if (rd_q.size() == 0) chk("data_out_valid_unexpected", data_out_valid, 0);
          else chk("cpu_read_data", DATA_OUT, rd_q.pop_front());
        end
        if (ram_read && ram_write) viol++;
        if (prev_cmd && (ram_read || ram_write) && ram_address != prev_addr) viol++;
      end
      prev_dov = data_out_valid; prev_cmd = ram_read | ram_write; prev_addr = ram_address;
    end
  end

  task automatic cpu_cycle(input logic [19:0] a, input logic io, input logic wr,
                           input logic [7:0] d);
    bit shared;
    int low, t;
    shared = !io && (a < 20'h20000);
    low = 0;
    tick(); ALE = 1'b1; ADDRESS = a; IO_OR_M = io;
    tick(); ALE = 1'b0; ADDRESS = '0;
    @(negedge clock);
    chk("rdy_after_ale", RDY, !shared);
    if (wr) begin WR_N = 1'b0; DATA_IN = d; end
    else RD_N = 1'b0;
    if (shared) begin
      if (wr) begin wr_q.push_back({a[16:0], d}); model[a[16:0]] = d; end
      else rd_q.push_back(model[a[16:0]]);
      t = 0;
      do begin @(negedge clock); t++; end while (!RDY && t < 400);
      if (t >= 400) chk("rdy_wait_timeout", RDY, 1);
      @(negedge clock); @(negedge clock);
      RD_N = 1'b1; WR_N = 1'b1;
      @(negedge clock); @(negedge clock);
      chk("data_out_valid_cleared", data_out_valid, 0);
    end else begin
      repeat (3) begin @(negedge clock); if (!RDY) low++; end
      RD_N = 1'b1; WR_N = 1'b1;
      @(negedge clock);
      chk("rdy_held_nonshared", low, 0);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((vid_q.size() != 0 || mbusy) && t < 300) begin @(negedge clock); t++; end
    chk("video_drained", vid_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish within cycle budget");
    $fatal(1);
  end

  initial begin
    int n0, t, k;
    logic [19:0] a;
    logic [16:0] va;
    logic [7:0]  d;
    for (int i = 0; i < 131072; i++) begin
      ram[i] = 8'((i * 37) ^ (i >> 9));
      model[i] = ram[i];
    end
    ram[17'h01234] = 8'hA5; model[17'h01234] = 8'hA5;

    repeat (3) tick();
    @(negedge clock);
    chk("rst_RDY", RDY, 1);
    chk("rst_DATA_OUT", DATA_OUT, 0);
    chk("rst_data_out_valid", data_out_valid, 0);
    chk("rst_video_busy", video_busy, 0);
    chk("rst_video_ack", video_ack, 0);
    chk("rst_video_data", video_data, 0);
    chk("rst_ram_read", ram_read, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_address", ram_address, 0);
    chk("rst_ram_data_out", ram_data_out, 0);
    reset = 1'b0;

    // Shared read with a 3-clock RAM ack.
    fixed_dly = 3;
    n0 = cmd_log.size();
    cpu_cycle(20'h01234, 0, 0, 8'h00);
    chk("read_cmd_addr", cmd_log[n0].a, 17'h01234);
    chk("read_cmd_dir", cmd_log[n0].w, 0);
    fixed_dly = 0;

    // Non-shared memory and I/O cycles leave RAM alone.
    n0 = cmd_log.size();
    cpu_cycle(20'hB8000, 0, 0, 8'h00);
    cpu_cycle(20'h000A0, 1, 1, 8'h77);
    chk("nonshared_no_ram_cmd", cmd_log.size(), n0);

    // Shared write at the top of the window, then read it back.
    cpu_cycle(20'h1FFFF, 0, 1, 8'h3C);
    cpu_cycle(20'h1FFFF, 0, 0, 8'h00);

    // Video latency from idle: ram_read one clock after video_req.
    @(negedge clock); vid_pct = 100; vid_en = 1;
    @(negedge clock); vid_en = 0; va = video_address;
    chk("video_busy_before_accept", video_busy, 0);
    @(negedge clock);
    chk("video_ram_read_latency", ram_read, 1);
    chk("video_ram_address", ram_address, va);
    chk("video_busy_after_accept", video_busy, 1);
    drain();

    // Priority: video request and shared CPU write in the same cycle.
    n0 = cmd_log.size();
    @(negedge clock); vid_pct = 100; vid_en = 1;
    fork
      cpu_cycle(20'h1ABCD, 0, 1, 8'h5A);
      begin @(negedge clock); vid_en = 0; end
    join
    drain();
    va = video_address;
    chk("prio_first_is_video", {cmd_log[n0].w, cmd_log[n0].a}, {1'b0, va});
    chk("prio_second_is_cpu", {cmd_log[n0+1].w, cmd_log[n0+1].a}, {1'b1, 17'h1ABCD});

    // Starvation guard: continuous video requests, CPU gets in after 4 acks.
    @(negedge clock); acks_in_wait = 0; vid_pct = 100; vid_en = 1;
    cpu_cycle(20'h11111, 0, 0, 8'h00);
    @(negedge clock); vid_en = 0;
    drain();
    chk("starvation_video_acks", acks_in_wait, 4);

    // Reset while a video read is outstanding; a late ram_ack must be ignored.
    ram_hold = 1;
    @(negedge clock); vid_pct = 100; vid_en = 1;
    @(negedge clock); vid_en = 0;
    t = 0;
    while (!ram_read && t < 20) begin @(negedge clock); t++; end
    chk("ram_read_before_reset", ram_read, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_ram_read", ram_read, 0);
    chk("mid_rst_RDY", RDY, 1);
    chk("mid_rst_video_busy", video_busy, 0);
    reset = 1'b0;
    vid_q.delete(); mbusy = 0; ram_hold = 0;
    n0 = vid_acks;
    stray = 1;
    repeat (6) @(negedge clock);
    chk("stray_ack_no_video_ack", vid_acks - n0, 0);

    // Random mix of CPU cycles under background video traffic.
    @(negedge clock); vid_pct = 40; vid_en = 1;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(3);
      d = 8'($urandom);
      case (k)
        0: cpu_cycle(20'($urandom_range(32'h1FFFF)), 0, 0, d);
        1: cpu_cycle(20'h10000 + 20'($urandom_range(32'hFFFF)), 0, 1, d);
        2: cpu_cycle(20'h20000 + 20'($urandom_range(32'hDFFFF)), 0, 1'($urandom), d);
        default: cpu_cycle(20'($urandom), 1, 1'($urandom), d);
      endcase
    end
    @(negedge clock); vid_en = 0;
    drain();

    chk("cpu_read_queue_empty", rd_q.size(), 0);
    chk("ram_write_queue_empty", wr_q.size(), 0);
    chk("ram_cmd_protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
